// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the program/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_AW           = 8;
    localparam int unsigned DEF_DW           = 8;
    localparam int unsigned DEF_STARVE_LIMIT = 3;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOCK = 2'd1,
        HOST = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_F    = 2'd1,
        REQ_D    = 2'd2,
        REQ_H    = 2'd3
    } req_id_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles fetch has waited; flags when fetch must win.
module arb_starve_ctr #(
    parameter int unsigned LIMIT = 3,
    parameter int unsigned CW    = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic          f_gnt,
    output logic [CW-1:0] cnt,
    output logic          at_limit_c
);

    // Count lost fetch cycles, clear on grant or idle, hold at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!f_req || f_gnt) begin
            cnt <= '0;
        end else if (cnt != CW'(LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_limit_c = (cnt == CW'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch, data and (optional) host requesters.
// Define MEM_ARB_HOST_EN to include the host port, h_lock and the LOCK/HOST states.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = DEF_AW,
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
`ifdef MEM_ARB_HOST_EN
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    input  logic          h_lock,
    output logic          h_gnt,
    output logic          h_ack,
    output logic          host_mode,
`endif
    output logic          f_gnt,
    output logic          d_gnt,
    output logic          f_ack,
    output logic          d_ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_stall
);

    localparam int unsigned SCW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_t     state;
    arb_state_t     state_nxt;
    req_id_t        sel;
    logic [SCW-1:0] starve_cnt;
    logic           starved_c;

    logic           h_req_i;
    logic           h_we_i;
    logic [AW-1:0]  h_addr_i;
    logic [DW-1:0]  h_wdata_i;
    logic           h_lock_i;

`ifdef MEM_ARB_HOST_EN
    assign h_req_i   = h_req;
    assign h_we_i    = h_we;
    assign h_addr_i  = h_addr;
    assign h_wdata_i = h_wdata;
    assign h_lock_i  = h_lock;
`else
    assign h_req_i   = 1'b0;
    assign h_we_i    = 1'b0;
    assign h_addr_i  = '0;
    assign h_wdata_i = '0;
    assign h_lock_i  = 1'b0;
`endif

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CW    (SCW)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .f_req      (f_req),
        .f_gnt      (f_gnt),
        .cnt        (starve_cnt),
        .at_limit_c (starved_c)
    );

    // Ownership state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next ownership state and priority select of this cycle's single grant.
    always_comb begin
        state_nxt = state;
        sel       = REQ_NONE;
        case (state)
            RUN: begin
                if (h_req_i) begin
                    sel = REQ_H;
                end else if (f_req && starved_c) begin
                    sel = REQ_F;
                end else if (d_req) begin
                    sel = REQ_D;
                end else if (f_req) begin
                    sel = REQ_F;
                end
                if (h_lock_i) begin
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (h_req_i) begin
                    sel = REQ_H;
                end
                state_nxt = HOST;
            end
            HOST: begin
                if (h_req_i) begin
                    sel = REQ_H;
                end
                if (!h_lock_i) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (rst) begin
            sel = REQ_NONE;
        end
    end

    assign f_gnt     = (sel == REQ_F);
    assign d_gnt     = (sel == REQ_D);
    assign cpu_stall = (f_req && !f_gnt) || (d_req && !d_gnt);
    assign rdata     = mem_rdata;

    // Drive the memory from the granted requester; idle cycles are fetch-address reads.
    always_comb begin
        mem_addr  = f_addr;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (sel)
            REQ_D: begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_we    = d_we;
            end
            REQ_H: begin
                mem_addr  = h_addr_i;
                mem_wdata = h_wdata_i;
                mem_we    = h_we_i;
            end
            default: begin
            end
        endcase
    end

    // Acks trail their grant by exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
        end else begin
            f_ack <= f_gnt;
            d_ack <= d_gnt;
        end
    end

`ifdef MEM_ARB_HOST_EN
    assign h_gnt     = (sel == REQ_H);
    assign host_mode = (state == HOST);

    // Host ack trails its grant by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_ack <= 1'b0;
        end else begin
            h_ack <= h_gnt;
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and access sequencer for the processor's single-port program/data memory. It shares the memory among three requesters:
- instruction fetch, driven from the PC;
- data load/store, driven from the accumulator address path;
- an optional host loader port for program download and debug.

It sits between the control unit/datapath and the memory, returns acknowledgements, and drives a stall to the processor whenever a CPU request loses arbitration.

## Interface
Parameters:
- AW, 8, address width
- DW, 8, data width
- STARVE_LIMIT, 3, consecutive lost cycles after which fetch beats data

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request, level; held until f_gnt
- f_addr  in  AW  fetch address
- d_req  in  1  data request, level; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- h_req, h_we, h_addr, h_wdata  in  1/1/AW/DW  host request fields (MEM_ARB_HOST_EN only)
- h_lock  in  1  host requests exclusive ownership (MEM_ARB_HOST_EN only)
- f_gnt, d_gnt, h_gnt  out  1  combinational grant, same cycle as the memory drive
- f_ack, d_ack, h_ack  out  1  registered, asserted one cycle after the matching gnt
- rdata  out  DW  equals mem_rdata, valid when any ack is high
- mem_addr  out  AW  address to memory
- mem_wdata  out  DW  write data to memory
- mem_we  out  1  memory write enable
- mem_rdata  in  DW  memory read data, valid one cycle after address
- cpu_stall  out  1  f_req or d_req high and not granted this cycle
- host_mode  out  1  FSM in HOST

## Operation
- At most one grant per cycle. Accesses are fully pipelined: a new grant is legal every cycle.
- Priority in RUN: host > data > fetch.
- Exception: if starve_cnt == STARVE_LIMIT, fetch beats data. Host still wins.
- starve_cnt:
  - increments when f_req is high and f_gnt is low;
  - clears on f_gnt or when f_req is low;
  - saturates at STARVE_LIMIT.
- Memory drive:
  - mem_addr, mem_wdata and mem_we come from the granted requester.
  - With no grant: mem_we = 0 and mem_addr = f_addr, a don't-care read.
- Acks:
  - ack_x <= gnt_x every cycle.
  - Loads take rdata while ack is high.
  - Stores complete at ack; rdata is ignored.
- FSM states: RUN, LOCK, HOST.
  - RUN: normal arbitration. h_lock = 1 -> LOCK.
  - LOCK: no CPU grants (cpu_stall follows f_req|d_req); host may be granted. Always -> HOST next cycle, which lets any in-flight CPU ack retire.
  - HOST: only h_req is granted. host_mode = 1. h_lock = 0 -> RUN.
- Simultaneous h_lock rise and a CPU grant in RUN: the grant is issued; LOCK follows.
- Reset mid-access: all acks clear and the outstanding access is dropped. Requesters re-issue.

## Timing
- Reset values:
  - all ack outputs 0;
  - starve_cnt 0, FSM RUN, host_mode 0;
  - all gnt outputs 0 and mem_we 0 while rst is high.
- Grant latency: 0 cycles, combinational from req.
- Ack latency: exactly 1 cycle after gnt.
- Load-to-use: data available at the cycle of ack.
- Worst-case fetch wait with d_req held continuously: STARVE_LIMIT cycles, then one fetch grant (host idle).

## Configuration
- MEM_ARB_HOST_EN defined:
  - host port and h_lock present;
  - LOCK/HOST states present;
  - host has top priority.
- Not defined:
  - host ports and host_mode are removed;
  - FSM is fixed in RUN;
  - arbitration is data > fetch with the starvation guard only.

## Structure
- Shared package mem_arb_pkg holds:
  - arb_state_t (RUN, LOCK, HOST);
  - requester id enum (REQ_NONE, REQ_F, REQ_D, REQ_H);
  - default AW/DW constants matching the 8-bit datapath.
- One sub-module, arb_starve_ctr: the saturating starvation counter with its limit compare output.
- Priority select and memory mux stay inline in mem_arbiter.

## Test plan
- Fetch only: f_req = 1, f_addr = 0x10, mem holds 0xA5 -> f_gnt the same cycle; f_ack and rdata = 0xA5 one cycle later. Repeats back-to-back at 0x11 with no bubble.
- Fetch + data store, same cycle: d_req = 1, d_we = 1, d_addr = 0x40, d_wdata = 0x3C -> d_gnt, mem_we = 1, cpu_stall = 1; fetch is granted next cycle. A later load of 0x40 returns 0x3C.
- Starvation: d_req held high for 10 cycles with f_req high -> fetch granted on cycle 4 (STARVE_LIMIT = 3); starve_cnt then returns to 0.
- Host lock (MEM_ARB_HOST_EN): h_lock rises during a CPU load -> the load acks; LOCK for 1 cycle; HOST with host_mode = 1. Host writes 0x77 to 0x00 -> h_ack. No f_gnt until h_lock = 0.
- Reset mid-access: assert rst in the cycle after d_gnt -> d_ack = 0, FSM RUN, starve_cnt 0, no mem_we during reset.
- Build without MEM_ARB_HOST_EN: the same fetch/data scenarios pass, and the h_* ports are absent.
